h2c_ib_packer: RTL

Inbound write stage between the XDMA H2C AXI-Stream channel 0 and the inbound half of Mem. It packs 64-bit H2C beats into 128-bit Mem words and writes each packet into one of 8 fixed-size slots. It flags a slot as full in DataValid once its packet has been written. The downstream consumer (Crypto side) releases the slot through RamValid.

---
 rtl/h2c_ib_packer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/h2c_ib_packer.sv
// Packs 64-bit H2C AXI-Stream beats into 128-bit Mem words, one packet per slot.
// Slots are marked full in DataValid and released by the consumer via RamValid.
module h2c_ib_packer #(
    parameter int DATA_W = 64,
    parameter int MEM_W  = 128,
    parameter int ADDR_W = 12,
    parameter int SLOTS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   m_axis_h2c_tdata_0,
    input  logic [DATA_W/8-1:0] m_axis_h2c_tkeep_0,
    input  logic                m_axis_h2c_tlast_0,
    input  logic                m_axis_h2c_tvalid_0,
    output logic                m_axis_h2c_tready_0,
    output logic [MEM_W-1:0]    WrData,
    output logic                WrEn,
    output logic [ADDR_W-1:0]   WrAddr,
    output logic [SLOTS-1:0]    DataValid,
    input  logic [SLOTS-1:0]    RamValid,
    output logic                ErrOvf
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int OFF_W  = ADDR_W - SLOT_W;
    localparam logic [OFF_W-1:0] OFF_MAX = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic [OFF_W-1:0]  word_off_q, word_off_d;
    logic              half_q, half_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              wr_en_q, wr_en_d;
    logic [MEM_W-1:0]  wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [SLOTS-1:0]  data_valid_q, data_valid_d;
    logic              err_ovf_q, err_ovf_d;

    logic [DATA_W-1:0] beat_m;
    logic [SLOTS-1:0]  set_mask;
    logic              tready;
    logic              accept;

    assign tready = (state_q == S_RECV) || (state_q == S_DROP);
    assign accept = tready && m_axis_h2c_tvalid_0;

    always_comb begin
        beat_m = '0;
        for (int k = 0; k < KEEP_W; k++) begin
            if (m_axis_h2c_tkeep_0[k]) begin
                beat_m[k*8 +: 8] = m_axis_h2c_tdata_0[k*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_slot_d  = wr_slot_q;
        word_off_d = word_off_q;
        half_d     = half_q;
        hold_d     = hold_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
        err_ovf_d  = err_ovf_q;
        set_mask   = '0;
        case (state_q)
            S_IDLE: begin
                if (!data_valid_q[wr_slot_q]) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    if (!half_q && !m_axis_h2c_tlast_0) begin
                        hold_d = beat_m;
                        half_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = half_q ? {beat_m, hold_q}
                                           : {{DATA_W{1'b0}}, beat_m};
                        wr_addr_d = {wr_slot_q, word_off_q};
                        half_d    = 1'b0;
                        // A full slot closes the packet early; the rest is dropped.
                        if (m_axis_h2c_tlast_0 || word_off_q == OFF_MAX) begin
                            set_mask   = SLOTS'(1) << wr_slot_q;
                            wr_slot_d  = wr_slot_q + SLOT_W'(1);
                            word_off_d = '0;
                            if (m_axis_h2c_tlast_0) begin
                                state_d = S_IDLE;
                            end else begin
                                state_d   = S_DROP;
                                err_ovf_d = 1'b1;
                            end
                        end else begin
                            word_off_d = word_off_q + OFF_W'(1);
                        end
                    end
                end
            end
            S_DROP: begin
                if (accept && m_axis_h2c_tlast_0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Set beats release when both hit the same slot.
        data_valid_d = (data_valid_q & ~RamValid) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_slot_q    <= '0;
            word_off_q   <= '0;
            half_q       <= 1'b0;
            hold_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            data_valid_q <= '0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_slot_q    <= wr_slot_d;
            word_off_q   <= word_off_d;
            half_q       <= half_d;
            hold_q       <= hold_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            data_valid_q <= data_valid_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign m_axis_h2c_tready_0 = tready;
    assign WrEn      = wr_en_q;
    assign WrData    = wr_data_q;
    assign WrAddr    = wr_addr_q;
    assign DataValid = data_valid_q;
    assign ErrOvf    = err_ovf_q;

endmodule
